fetch_predict_cache: RTL and testbench

FETCH_PREDICT_CACHE -- requirements
Module: fetch_predict_cache

---
 rtl/fetch_predict_cache_pkg.sv | 27 ++
 rtl/fetch_predict_cache_branch_predictor.sv | 80 ++++++++
 rtl/fetch_predict_cache_icache.sv | 74 +++++++
 rtl/fetch_predict_cache.sv | 72 +++++++
 tb/tb_fetch_predict_cache.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_predict_cache_pkg.sv
// Shared constants and predictor counter encoding for the fetch/predict/cache slice.
package fetch_predict_cache_pkg;

   localparam int unsigned WORD_SIZE       = 32;
   localparam int unsigned CACHE_LINE_SIZE = 128;
   localparam logic [31:0] NOP             = 32'h0000_0013;
   localparam logic [31:0] PC_INITIAL      = 32'h0000_0000;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_t;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken) begin
         if (c != CTR_ST) n = ctr_t'(c + 2'd1);
      end else begin
         if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
      end
      return n;
   endfunction

endpackage

// File: rtl/fetch_predict_cache_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module branch_predictor
   import fetch_predict_cache_pkg::*;
#(
   parameter int unsigned WORD_W  = WORD_SIZE,
   parameter int unsigned ENTRIES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] pc,
   input  logic [WORD_W-1:0] pce,
   input  logic              branch_e,
   input  logic              zero_e,
   input  logic [WORD_W-1:0] pc_target_e,
   input  logic [WORD_W-1:0] saved_pc,
   input  logic              reset_branch,
   output logic              taking_branch,
   output logic [WORD_W-1:0] pred_target
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [WORD_W-1:0]  target_q [ENTRIES];
   logic [WORD_W-1:0]  target_d [ENTRIES];
   ctr_t               ctr_q    [ENTRIES];
   ctr_t               ctr_d    [ENTRIES];
   logic [IDX_W-1:0]   l_idx, u_idx, r_idx;
   logic [TAG_W-1:0]   l_tag, u_tag, r_tag;
   logic               unused_low_bits;

   always_comb begin
      l_idx           = pc[2 +: IDX_W];
      l_tag           = pc[2 + IDX_W +: TAG_W];
      u_idx           = pce[2 +: IDX_W];
      u_tag           = pce[2 + IDX_W +: TAG_W];
      r_idx           = saved_pc[2 +: IDX_W];
      r_tag           = saved_pc[2 + IDX_W +: TAG_W];
      unused_low_bits = ^{pc[1:0], pce[1:0], saved_pc[1:0]};
      taking_branch   = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && ctr_q[l_idx][1];
      pred_target     = target_q[l_idx];
      valid_d         = valid_q;
      tag_d           = tag_q;
      target_d        = target_q;
      ctr_d           = ctr_q;
      if (branch_e) begin
         if (valid_q[u_idx] && (tag_q[u_idx] == u_tag)) begin
            ctr_d[u_idx] = ctr_next(ctr_q[u_idx], zero_e);
            if (zero_e) target_d[u_idx] = pc_target_e;
         end else begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = pc_target_e;
            ctr_d[u_idx]    = zero_e ? CTR_WT : CTR_WNT;
         end
      end
      // Invalidation is judged against the post-update entry so it overrides a same-cycle allocate.
      if (reset_branch && valid_d[r_idx] && (tag_d[r_idx] == r_tag)) valid_d[r_idx] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

endmodule

// File: rtl/fetch_predict_cache_icache.sv
// Direct-mapped instruction cache; misses stall fetch and request a whole line.
module icache
   import fetch_predict_cache_pkg::*;
#(
   parameter int unsigned       WORD_W   = WORD_SIZE,
   parameter int unsigned       LINE_W   = CACHE_LINE_SIZE,
   parameter int unsigned       LINES    = 4,
   parameter logic [WORD_W-1:0] NOP_WORD = NOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] pc,
   input  logic [LINE_W-1:0] mem_line,
   input  logic              mem_ready,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc_mem,
   output logic              mem_read,
   output logic              stall
);

   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = WORD_W - OFF_W - IDX_W;
   localparam int unsigned SEL_W = OFF_W - 2;

   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [LINE_W-1:0] data_q [LINES];
   logic [LINE_W-1:0] data_d [LINES];
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [SEL_W-1:0]  sel;
   int unsigned       word_off;
   logic              hit;
   logic              unused_pc_bits;

   always_comb begin
      idx            = pc[OFF_W +: IDX_W];
      tag            = pc[OFF_W + IDX_W +: TAG_W];
      sel            = pc[2 +: SEL_W];
      unused_pc_bits = ^pc[1:0];
      word_off       = 32'(sel) * WORD_W;
      hit            = valid_q[idx] && (tag_q[idx] == tag);
      instr          = hit ? data_q[idx][word_off +: WORD_W] : NOP_WORD;
      mem_read       = !hit;
      stall          = !hit;
      pc_mem         = {pc[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
      valid_d        = valid_q;
      tag_d          = tag_q;
      data_d         = data_q;
      // A returning line is only accepted while the current PC misses.
      if (!hit && mem_ready) begin
         valid_d[idx] = 1'b1;
         tag_d[idx]   = tag;
         data_d[idx]  = mem_line;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/fetch_predict_cache.sv
// Fetch stage front end: I-cache lookup plus next-PC prediction from the BTB.
module fetch_predict_cache #(
   parameter int unsigned          WORD_SIZE       = fetch_predict_cache_pkg::WORD_SIZE,
   parameter int unsigned          CACHE_LINE_SIZE = fetch_predict_cache_pkg::CACHE_LINE_SIZE,
   parameter int unsigned          CACHE_LINES     = 4,
   parameter int unsigned          BTB_ENTRIES     = 8,
   parameter logic [WORD_SIZE-1:0] NOP             = fetch_predict_cache_pkg::NOP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WORD_SIZE-1:0]       PC,
   input  logic [WORD_SIZE-1:0]       PCE,
   input  logic                       BranchE,
   input  logic                       ZeroE,
   input  logic [WORD_SIZE-1:0]       PCTargetE,
   input  logic [WORD_SIZE-1:0]       SavedPC,
   input  logic                       resetBranch,
   input  logic [CACHE_LINE_SIZE-1:0] MemLine,
   input  logic                       MemReady,
   output logic [WORD_SIZE-1:0]       PCPlus4,
   output logic [WORD_SIZE-1:0]       NextInstruction,
   output logic                       TakingBranch,
   output logic [WORD_SIZE-1:0]       Instr,
   output logic [WORD_SIZE-1:0]       PCMem,
   output logic                       MemRead,
   output logic                       CacheStall
);

   import fetch_predict_cache_pkg::*;

   logic [WORD_SIZE-1:0] pred_target;

   always_comb begin
      PCPlus4         = PC + WORD_SIZE'(4);
      NextInstruction = TakingBranch ? pred_target : PCPlus4;
   end

   icache #(
      .WORD_W   (WORD_SIZE),
      .LINE_W   (CACHE_LINE_SIZE),
      .LINES    (CACHE_LINES),
      .NOP_WORD (NOP)
   ) u_icache (
      .clk       (clk),
      .rst       (rst),
      .pc        (PC),
      .mem_line  (MemLine),
      .mem_ready (MemReady),
      .instr     (Instr),
      .pc_mem    (PCMem),
      .mem_read  (MemRead),
      .stall     (CacheStall)
   );

   branch_predictor #(
      .WORD_W  (WORD_SIZE),
      .ENTRIES (BTB_ENTRIES)
   ) u_branch_predictor (
      .clk           (clk),
      .rst           (rst),
      .pc            (PC),
      .pce           (PCE),
      .branch_e      (BranchE),
      .zero_e        (ZeroE),
      .pc_target_e   (PCTargetE),
      .saved_pc      (SavedPC),
      .reset_branch  (resetBranch),
      .taking_branch (TakingBranch),
      .pred_target   (pred_target)
   );

endmodule

// File: tb/tb_fetch_predict_cache.sv
// Directed scoreboard bench for fetch_predict_cache: cache fill/hit/miss and predictor training.
module tb_fetch_predict_cache;

   typedef enum int {O_INSTR, O_STALL, O_MEMREAD, O_PCMEM, O_TAKE, O_NEXT, O_PLUS4} obs_e;
   typedef struct {
      string       name;
      obs_e        sig;
      logic [31:0] exp;
   } exp_t;

   logic         clk, rst;
   logic [31:0]  PC, PCE, PCTargetE, SavedPC;
   logic         BranchE, ZeroE, resetBranch, MemReady;
   logic [127:0] MemLine;
   logic [31:0]  PCPlus4, NextInstruction, Instr, PCMem;
   logic         TakingBranch, MemRead, CacheStall;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   fetch_predict_cache #(
      .CACHE_LINES (4),
      .BTB_ENTRIES (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .PC              (PC),
      .PCE             (PCE),
      .BranchE         (BranchE),
      .ZeroE           (ZeroE),
      .PCTargetE       (PCTargetE),
      .SavedPC         (SavedPC),
      .resetBranch     (resetBranch),
      .MemLine         (MemLine),
      .MemReady        (MemReady),
      .PCPlus4         (PCPlus4),
      .NextInstruction (NextInstruction),
      .TakingBranch    (TakingBranch),
      .Instr           (Instr),
      .PCMem           (PCMem),
      .MemRead         (MemRead),
      .CacheStall      (CacheStall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   task automatic expect_val(input string n, input obs_e s, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sig  = s;
      e.exp  = v;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input obs_e s);
      case (s)
         O_INSTR:   return Instr;
         O_STALL:   return {31'd0, CacheStall};
         O_MEMREAD: return {31'd0, MemRead};
         O_PCMEM:   return PCMem;
         O_TAKE:    return {31'd0, TakingBranch};
         O_NEXT:    return NextInstruction;
         O_PLUS4:   return PCPlus4;
         default:   return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sig);
         checks++;
         assert (o === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.name, o, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic b, input logic z, input logic [31:0] pce_v, input logic [31:0] tgt);
      BranchE   = b;
      ZeroE     = z;
      PCE       = pce_v;
      PCTargetE = tgt;
   endtask

   initial begin
      rst = 1'b1; PC = 32'h0; SavedPC = 32'h0; resetBranch = 1'b0;
      MemReady = 1'b0; MemLine = '0;
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      expect_val("rst_memread", O_MEMREAD, 32'd1);
      expect_val("rst_stall",   O_STALL,   32'd1);
      expect_val("rst_instr",   O_INSTR,   32'h13);
      expect_val("rst_take",    O_TAKE,    32'd0);
      expect_val("rst_next",    O_NEXT,    32'h4);
      expect_val("rst_plus4",   O_PLUS4,   32'h4);
      expect_val("rst_pcmem",   O_PCMEM,   32'h0);
      drain();
      @(negedge clk);
      rst = 1'b0;

      PC = 32'h1000;
      expect_val("miss_memread", O_MEMREAD, 32'd1);
      expect_val("miss_pcmem",   O_PCMEM,   32'h1000);
      expect_val("miss_stall",   O_STALL,   32'd1);
      expect_val("miss_instr",   O_INSTR,   32'h13);
      drain();

      MemLine = {32'd4, 32'd3, 32'd2, 32'd1};
      MemReady = 1'b1;
      PC = 32'h1008;
      expect_val("prefill_stall", O_STALL, 32'd1);
      drain();
      tick();
      MemReady = 1'b0;
      expect_val("fill_instr",   O_INSTR,   32'd3);
      expect_val("fill_stall",   O_STALL,   32'd0);
      expect_val("fill_memread", O_MEMREAD, 32'd0);
      drain();
      PC = 32'h1000;
      expect_val("word0", O_INSTR, 32'd1);
      drain();
      PC = 32'h100C;
      expect_val("word3", O_INSTR, 32'd4);
      drain();

      PC = 32'h1004;
      MemReady = 1'b1;
      MemLine = {32'd8, 32'd7, 32'd6, 32'd5};
      tick();
      MemReady = 1'b0;
      expect_val("ready_on_hit_ignored", O_INSTR, 32'd2);
      drain();

      PC = 32'h1040;
      expect_val("conflict_stall", O_STALL, 32'd1);
      expect_val("conflict_pcmem", O_PCMEM, 32'h1040);
      expect_val("conflict_instr", O_INSTR, 32'h13);
      drain();
      PC = 32'h1234;
      expect_val("retarget_pcmem", O_PCMEM, 32'h1230);
      drain();

      PC = 32'h1010;
      set_br(1'b1, 1'b1, 32'h1010, 32'h2000);
      expect_val("alloc_pre_take", O_TAKE, 32'd0);
      expect_val("alloc_pre_next", O_NEXT, 32'h1014);
      drain();
      tick();
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      expect_val("alloc_take", O_TAKE, 32'd1);
      expect_val("alloc_next", O_NEXT, 32'h2000);
      drain();

      set_br(1'b1, 1'b0, 32'h1010, 32'h4444);
      expect_val("same_cycle_pre_state", O_TAKE, 32'd1);
      drain();
      tick();
      expect_val("nt1_take", O_TAKE, 32'd0);
      expect_val("nt1_next", O_NEXT, 32'h1014);
      drain();
      tick();
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      expect_val("nt2_take", O_TAKE, 32'd0);
      expect_val("nt2_next", O_NEXT, 32'h1014);
      drain();

      set_br(1'b1, 1'b1, 32'h1010, 32'h2000);
      tick();
      expect_val("t_from_00_take", O_TAKE, 32'd0);
      drain();
      tick();
      expect_val("t_to_10_take", O_TAKE, 32'd1);
      expect_val("t_to_10_next", O_NEXT, 32'h2000);
      drain();
      set_br(1'b1, 1'b1, 32'h1010, 32'h3000);
      tick();
      expect_val("retarget_next", O_NEXT, 32'h3000);
      drain();
      set_br(1'b1, 1'b0, 32'h1010, 32'h4444);
      tick();
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      expect_val("sat_nt_take", O_TAKE, 32'd1);
      expect_val("sat_nt_next", O_NEXT, 32'h3000);
      drain();

      PC = 32'h1030;
      expect_val("alias_take", O_TAKE, 32'd0);
      expect_val("alias_next", O_NEXT, 32'h1034);
      drain();

      PC = 32'h1010;
      resetBranch = 1'b1;
      SavedPC = 32'h1030;
      tick();
      resetBranch = 1'b0;
      expect_val("inval_tag_mismatch", O_TAKE, 32'd1);
      drain();

      resetBranch = 1'b1;
      SavedPC = 32'h1010;
      set_br(1'b1, 1'b1, 32'h1010, 32'h5000);
      tick();
      resetBranch = 1'b0;
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      expect_val("inval_wins_take", O_TAKE, 32'd0);
      expect_val("inval_wins_next", O_NEXT, 32'h1014);
      drain();

      PC = 32'h8000;
      set_br(1'b1, 1'b1, 32'h8000, 32'h9000);
      expect_val("stall_pre", O_STALL, 32'd1);
      drain();
      tick();
      set_br(1'b0, 1'b0, 32'h0, 32'h0);
      expect_val("stall_update_stall", O_STALL, 32'd1);
      expect_val("stall_update_take",  O_TAKE,  32'd1);
      expect_val("stall_update_next",  O_NEXT,  32'h9000);
      drain();

      PC = 32'hFFFF_FFFC;
      expect_val("wrap_plus4", O_PLUS4, 32'h0);
      expect_val("wrap_next",  O_NEXT,  32'h0);
      drain();

      PC = 32'h1008;
      expect_val("pre_rst_instr", O_INSTR, 32'd3);
      drain();
      rst = 1'b1;
      expect_val("async_rst_stall", O_STALL, 32'd1);
      expect_val("async_rst_instr", O_INSTR, 32'h13);
      drain();
      PC = 32'h8000;
      expect_val("async_rst_take", O_TAKE, 32'd0);
      expect_val("async_rst_next", O_NEXT, 32'h8004);
      drain();
      @(negedge clk);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
